// File: rtl/data_memory_hs.sv
// Byte-addressable big-endian data memory with valid/ready request/response handshake.
// Optional misalignment faulting is enabled by defining DMEM_MISALIGN_TRAP_EN.
module data_memory_hs #(
  parameter int    ADDR_BITS = 6,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_fault
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic {
    IDLE  = 1'b0,
    BEAT2 = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [7:0]           mem_q [DEPTH];

  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [31:0]          wdata_lo_q, wdata_lo_d;
  logic                 write_q, write_d;
  logic [31:0]          rd_hi_q, rd_hi_d;

  logic                 resp_valid_q, resp_valid_d;
  logic [63:0]          resp_rdata_q, resp_rdata_d;
  logic                 resp_fault_q, resp_fault_d;

  logic [ADDR_BITS-1:0] base_addr;
  logic [ADDR_BITS-1:0] lane_addr  [4];
  logic [7:0]           lane_wdata [4];
  logic [3:0]           lane_we;
  logic [31:0]          rd_word;
  logic [31:0]          beat_data;
  logic [2:0]           lane_cnt;
  logic                 mem_we;
  logic                 misalign;
  logic                 sext;
  logic [63:0]          load_ext;
  logic                 unused_addr;

  assign unused_addr = ^req_addr[63:ADDR_BITS];

  // Contents survive reset; only power-up initialisation applies.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem_q[i] = 8'h00;
  end

  // Beat 2 always covers the four bytes following the latched address.
  assign base_addr = (state_q == BEAT2) ? addr_q + ADDR_BITS'(4) : req_addr[ADDR_BITS-1:0];

  // Lane gi is the byte at base+gi, which is the (gi)-th most significant byte of the beat.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_addr[gi]            = base_addr + ADDR_BITS'(gi);
    assign lane_wdata[gi]           = beat_data[31-8*gi -: 8];
    assign lane_we[gi]              = mem_we && (3'(gi) < lane_cnt) && !reset;
    assign rd_word[31-8*gi -: 8]    = mem_q[lane_addr[gi]];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (lane_we[i]) mem_q[lane_addr[i]] <= lane_wdata[i];
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  always_comb begin
    case (req_size)
      2'b01:   misalign = req_addr[0];
      2'b10:   misalign = |req_addr[1:0];
      2'b11:   misalign = |req_addr[2:0];
      default: misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  assign sext = !req_unsigned;

  always_comb begin
    case (req_size)
      2'b00:   load_ext = {{56{sext & rd_word[31]}}, rd_word[31:24]};
      2'b01:   load_ext = {{48{sext & rd_word[31]}}, rd_word[31:16]};
      default: load_ext = {{32{sext & rd_word[31]}}, rd_word};
    endcase
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_lo_d   = wdata_lo_q;
    write_d      = write_q;
    rd_hi_d      = rd_hi_q;
    resp_valid_d = resp_valid_q && !resp_ready;
    resp_rdata_d = resp_rdata_q;
    resp_fault_d = resp_fault_q;
    req_ready    = 1'b0;
    beat_data    = 32'h0;
    lane_cnt     = 3'd0;
    mem_we       = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = !resp_valid_q || resp_ready;
        if (req_valid && req_ready) begin
          if (misalign) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = 64'h0;
            resp_fault_d = 1'b1;
          end else if (req_size == 2'b11) begin
            mem_we     = req_write;
            lane_cnt   = 3'd4;
            beat_data  = req_wdata[63:32];
            addr_d     = req_addr[ADDR_BITS-1:0];
            wdata_lo_d = req_wdata[31:0];
            write_d    = req_write;
            rd_hi_d    = rd_word;
            state_d    = BEAT2;
          end else begin
            mem_we = req_write;
            case (req_size)
              2'b00: begin
                lane_cnt  = 3'd1;
                beat_data = {req_wdata[7:0], 24'h0};
              end
              2'b01: begin
                lane_cnt  = 3'd2;
                beat_data = {req_wdata[15:0], 16'h0};
              end
              default: begin
                lane_cnt  = 3'd4;
                beat_data = req_wdata[31:0];
              end
            endcase
            resp_valid_d = 1'b1;
            resp_rdata_d = req_write ? 64'h0 : load_ext;
            resp_fault_d = 1'b0;
          end
        end
      end
      BEAT2: begin
        // The response slot is guaranteed empty here: it was freed on the accept edge.
        mem_we       = write_q;
        lane_cnt     = 3'd4;
        beat_data    = wdata_lo_q;
        resp_valid_d = 1'b1;
        resp_rdata_d = write_q ? 64'h0 : {rd_hi_q, rd_word};
        resp_fault_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_lo_q   <= 32'h0;
      write_q      <= 1'b0;
      rd_hi_q      <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 64'h0;
      resp_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_lo_q   <= wdata_lo_d;
      write_q      <= write_d;
      rd_hi_q      <= rd_hi_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_fault_q <= resp_fault_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_fault = resp_fault_q;

endmodule

// File: tb/tb_data_memory_hs.sv
// Scoreboard bench for data_memory_hs: expected responses queued at request time,
// checked when the DUT hands over each response.
module tb_data_memory_hs;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_fault;

  always #5 clk = ~clk;

  data_memory_hs #(.ADDR_BITS(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_fault   (resp_fault)
  );

  logic [64:0] exp_q [$];
  logic [64:0] mon_e;
  int n_cmp  = 0;
  int n_bad  = 0;
  int n_push = 0;
  int n_pop  = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake inputs are stable from negedge to the next posedge, so this sees each consumption once.
  always @(negedge clk) begin
    if (!reset && resp_valid && resp_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL resp_unexpected: got rdata=%h fault=%b, required no response", resp_rdata, resp_fault);
      end else begin
        mon_e = exp_q.pop_front();
        n_pop++;
        if ({resp_fault, resp_rdata} !== mon_e) begin
          n_bad++;
          $display("FAIL resp_%0d: got rdata=%h fault=%b, required rdata=%h fault=%b",
                   n_pop, resp_rdata, resp_fault, mon_e[63:0], mon_e[64]);
        end else begin
          $display("resp %0d: rdata=%h fault=%b", n_pop, resp_rdata, resp_fault);
        end
      end
    end
  end

  task automatic push_exp(input logic [63:0] er, input logic ef);
    exp_q.push_back({ef, er});
    n_push++;
  endtask

  task automatic set_req(input logic w, input logic [63:0] a, input logic [63:0] wd,
                         input logic [1:0] sz, input logic u);
    req_valid    = 1'b1;
    req_write    = w;
    req_addr     = a;
    req_wdata    = wd;
    req_size     = sz;
    req_unsigned = u;
  endtask

  // Returns #1 after the accept edge with req_valid still high.
  task automatic wait_accept(input string nm);
    int k;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 20) begin
      k++;
      @(negedge clk);
    end
    if (!req_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_accept_timeout: req_ready=%b, required 1", nm, req_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic w, input logic [63:0] a, input logic [63:0] wd,
                        input logic [1:0] sz, input logic u,
                        input logic [63:0] er, input logic ef);
    set_req(w, a, wd, sz, u);
    push_exp(er, ef);
    wait_accept("req");
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = 2'b00; req_unsigned = 1'b0; resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({resp_valid, resp_fault, resp_rdata} !== 66'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got valid=%b fault=%b rdata=%h, required all 0", resp_valid, resp_fault, resp_rdata);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_req_ready: got %b, required 1", req_ready);
    end
  endtask

  task automatic test_double;
    do_req(1'b1, 64'd8, 64'h0123456789ABCDEF, 2'b11, 1'b0, 64'h0, 1'b0);
    n_cmp++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL double_beat2: got resp_valid=%b req_ready=%b, required 0 0", resp_valid, req_ready);
    end
    idle(1);
    n_cmp++;
    if (resp_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL double_latency: got resp_valid=%b, required 1", resp_valid);
    end
    do_req(1'b0, 64'd8, 64'h0, 2'b11, 1'b1, 64'h0123456789ABCDEF, 1'b0);
    idle(1);
    do_req(1'b0, 64'd8,  64'h0, 2'b00, 1'b1, 64'h01, 1'b0);
    n_cmp++;
    if (resp_valid !== 1'b1 || resp_rdata !== 64'h01) begin
      n_bad++;
      $display("FAIL byte_latency: got valid=%b rdata=%h, required 1 %h", resp_valid, resp_rdata, 64'h01);
    end
    do_req(1'b0, 64'd15, 64'h0, 2'b00, 1'b1, 64'hEF, 1'b0);
    idle(2);
  endtask

  task automatic test_sign;
    do_req(1'b1, 64'd21, 64'h0,  2'b00, 1'b0, 64'h0, 1'b0);
    do_req(1'b1, 64'd20, 64'h80, 2'b00, 1'b0, 64'h0, 1'b0);
    do_req(1'b0, 64'd20, 64'h0,  2'b00, 1'b0, 64'hFFFFFFFFFFFFFF80, 1'b0);
    do_req(1'b0, 64'd20, 64'h0,  2'b00, 1'b1, 64'h0000000000000080, 1'b0);
    do_req(1'b0, 64'd20, 64'h0,  2'b01, 1'b0, 64'hFFFFFFFFFFFF8000, 1'b0);
    do_req(1'b0, 64'd20, 64'h0,  2'b01, 1'b1, 64'h0000000000008000, 1'b0);
    idle(2);
  endtask

  task automatic test_back_to_back;
    int c0;
    do_req(1'b1, 64'd4,  64'h12345678, 2'b10, 1'b0, 64'h0, 1'b0);
    do_req(1'b1, 64'd24, 64'h7EADBEEF, 2'b10, 1'b0, 64'h0, 1'b0);
    idle(2);
    resp_ready = 1'b0;
    do_req(1'b0, 64'd4, 64'h0, 2'b10, 1'b1, 64'h12345678, 1'b0);
    set_req(1'b0, 64'd24, 64'h0, 2'b10, 1'b0);
    push_exp(64'h7EADBEEF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (req_ready !== 1'b0 || resp_valid !== 1'b1 || resp_rdata !== 64'h12345678) begin
        n_bad++;
        $display("FAIL stall_hold_%0d: got ready=%b valid=%b rdata=%h, required 0 1 %h",
                 i, req_ready, resp_valid, resp_rdata, 64'h12345678);
      end
    end
    resp_ready = 1'b1;
    wait_accept("stall_release");
    n_cmp++;
    if (resp_valid !== 1'b1 || resp_rdata !== 64'h7EADBEEF) begin
      n_bad++;
      $display("FAIL stall_release: got valid=%b rdata=%h, required 1 %h", resp_valid, resp_rdata, 64'h7EADBEEF);
    end
    c0 = cyc;
    do_req(1'b0, 64'd8,  64'h0, 2'b10, 1'b1, 64'h01234567, 1'b0);
    do_req(1'b0, 64'd12, 64'h0, 2'b10, 1'b0, 64'hFFFFFFFF89ABCDEF, 1'b0);
    do_req(1'b0, 64'd9,  64'h0, 2'b01, 1'b1, 64'h2345, 1'b0);
    n_cmp++;
    if (cyc - c0 !== 3) begin
      n_bad++;
      $display("FAIL throughput: got %0d cycles for 3 loads, required 3", cyc - c0);
    end
    idle(2);
  endtask

  task automatic test_misalign;
`ifdef DMEM_MISALIGN_TRAP_EN
    do_req(1'b1, 64'd2, 64'h5A5A,     2'b01, 1'b0, 64'h0, 1'b0);
    do_req(1'b1, 64'd2, 64'hDEADBEEF, 2'b10, 1'b0, 64'h0, 1'b1);
    n_cmp++;
    if (resp_fault !== 1'b1) begin
      n_bad++;
      $display("FAIL misalign_fault: got %b, required 1", resp_fault);
    end
    do_req(1'b0, 64'd2, 64'h0, 2'b01, 1'b1, 64'h5A5A, 1'b0);
    do_req(1'b0, 64'd4, 64'h0, 2'b10, 1'b1, 64'h12345678, 1'b0);
    do_req(1'b0, 64'd12, 64'h0, 2'b11, 1'b0, 64'h0, 1'b1);
    do_req(1'b1, 64'd4, 64'hCAFEF00D, 2'b10, 1'b0, 64'h0, 1'b0);
    do_req(1'b0, 64'd4, 64'h0, 2'b10, 1'b1, 64'hCAFEF00D, 1'b0);
`else
    do_req(1'b1, 64'd62, 64'hAABBCCDD, 2'b10, 1'b0, 64'h0, 1'b0);
    do_req(1'b0, 64'd62, 64'h0, 2'b00, 1'b1, 64'hAA, 1'b0);
    do_req(1'b0, 64'd63, 64'h0, 2'b00, 1'b1, 64'hBB, 1'b0);
    do_req(1'b0, 64'd0,  64'h0, 2'b00, 1'b1, 64'hCC, 1'b0);
    do_req(1'b0, 64'd1,  64'h0, 2'b00, 1'b1, 64'hDD, 1'b0);
    do_req(1'b0, 64'd62, 64'h0, 2'b10, 1'b0, 64'hFFFFFFFFAABBCCDD, 1'b0);
    n_cmp++;
    if (resp_fault !== 1'b0) begin
      n_bad++;
      $display("FAIL legacy_no_fault: got %b, required 0", resp_fault);
    end
`endif
    idle(2);
  endtask

  task automatic test_reset_abort;
    do_req(1'b1, 64'd16, 64'hA0A1A2A3A4A5A6A7, 2'b11, 1'b0, 64'h0, 1'b0);
    idle(3);
    set_req(1'b1, 64'd16, 64'h1111111122222222, 2'b11, 1'b0);
    wait_accept("abort");
    reset = 1'b1;
    #1;
    n_cmp++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_state: got resp_valid=%b req_ready=%b, required 0 1", resp_valid, req_ready);
    end
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1);
    n_cmp++;
    if (resp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_no_resp: got resp_valid=%b, required 0", resp_valid);
    end
    do_req(1'b0, 64'd16, 64'h0, 2'b10, 1'b1, 64'h11111111, 1'b0);
    do_req(1'b0, 64'd20, 64'h0, 2'b10, 1'b1, 64'hA4A5A6A7, 1'b0);
    idle(2);
  endtask

  task automatic drain;
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      k++;
      @(posedge clk);
    end
    #1;
    n_cmp++;
    if (exp_q.size() != 0 || n_pop != n_push) begin
      n_bad++;
      $display("FAIL drain: got %0d responses of %0d expected", n_pop, n_push);
    end
  endtask

  initial begin
    test_reset;
    test_double;
    test_sign;
    test_back_to_back;
    test_misalign;
    test_reset_abort;
    drain;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
